// File: rtl/req_fork_sync.sv
`default_nettype none
// ============================================================================
// Module : req_fork_sync
// Brief  : Clocked four-phase request fork. Upstream ack is returned once all
//          enabled branches complete the phase. Includes a stall timeout flag.
// Rev    : 1.0
// ============================================================================
module req_fork_sync #(
    parameter int REQ_NUMBER = 3,
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_req,
    output logic                  in_ack,
    input  logic [REQ_NUMBER-1:0] en_mask,
    output logic [REQ_NUMBER-1:0] out_reqs,
    input  logic [REQ_NUMBER-1:0] out_acks,
    output logic [REQ_NUMBER-1:0] pending,
    output logic                  busy,
    output logic                  err,
    input  logic                  err_clr
);

    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] C_TO_MAX  = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_HOLD = 2'd2,
        S_FALL = 2'd3
    } state_t;

    state_t                state_q;
    logic [REQ_NUMBER-1:0] mask_q;
    logic [REQ_NUMBER-1:0] seen_q;
    logic [REQ_NUMBER-1:0] out_reqs_q;
    logic [TO_W-1:0]       count_q;
    logic                  in_ack_q;
    logic                  err_q;

    logic w_rise_done;
    logic w_fall_done;
    logic w_waiting;
    logic w_to_hit;

    // A branch counts as complete once its ack has been sampled in the
    // required level at least once this phase, so glitches are not revoked.
    assign w_rise_done = &(seen_q | out_acks | ~mask_q);
    assign w_fall_done = &(seen_q | ~out_acks | ~mask_q);
    assign w_waiting   = ((state_q == S_RISE) && !w_rise_done) ||
                         ((state_q == S_FALL) && !w_fall_done);
    assign w_to_hit    = w_waiting && (count_q == C_TO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            seen_q     <= '0;
            out_reqs_q <= '0;
            count_q    <= '0;
            in_ack_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Set is a one-shot event on reaching TIMEOUT, so a clear while
            // still stalled sticks; set beats a coincident clear.
            if (w_to_hit) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end

            if (w_waiting && (count_q != C_TO_MAX)) begin
                count_q <= count_q + TO_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (in_req) begin
                        mask_q     <= en_mask;
                        out_reqs_q <= en_mask;
                        seen_q     <= '0;
                        count_q    <= '0;
                        state_q    <= S_RISE;
                    end
                end
                S_RISE: begin
                    seen_q <= seen_q | out_acks;
                    if (w_rise_done) begin
                        in_ack_q <= 1'b1;
                        state_q  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!in_req) begin
                        out_reqs_q <= '0;
                        seen_q     <= '0;
                        count_q    <= '0;
                        state_q    <= S_FALL;
                    end
                end
                S_FALL: begin
                    seen_q <= seen_q | ~out_acks;
                    if (w_fall_done) begin
                        in_ack_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ack   = in_ack_q;
    assign out_reqs = out_reqs_q;
    assign err      = err_q;
    assign busy     = (state_q != S_IDLE);
    assign pending  = ((state_q == S_RISE) || (state_q == S_FALL)) ?
                      (mask_q & ~seen_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_req_fork_sync.sv
`default_nettype none
// ============================================================================
// Module : tb_req_fork_sync
// Brief  : Self-checking bench for req_fork_sync; expected timing is derived
//          per handshake from the ack arrival offsets. Rev : 1.0
// ============================================================================
module tb_req_fork_sync;

    localparam int C_N  = 3;
    localparam int C_TO = 10;

    logic           clk = 1'b0;
    logic           rstn;
    logic           in_req;
    logic           in_ack;
    logic [C_N-1:0] en_mask;
    logic [C_N-1:0] out_reqs;
    logic [C_N-1:0] out_acks;
    logic [C_N-1:0] pending;
    logic           busy;
    logic           err;
    logic           err_clr;

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_err  = 1'b0;
    bit   rand_clr = 1'b0;
    int   dly_r [C_N];
    int   dly_f [C_N];

    req_fork_sync #(
        .REQ_NUMBER(C_N),
        .TIMEOUT   (C_TO),
        .TO_W      (8)
    ) u_dut (
        .clk     (clk),
        .rstn    (rstn),
        .in_req  (in_req),
        .in_ack  (in_ack),
        .en_mask (en_mask),
        .out_reqs(out_reqs),
        .out_acks(out_acks),
        .pending (pending),
        .busy    (busy),
        .err     (err),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge; err expectation: a timeout event sets, else a clear clears.
    task automatic step(input bit set_ev, input bit force_clr);
        err_clr = force_clr | (rand_clr && ($urandom_range(0, 5) == 0));
        @(posedge clk);
        #1;
        if (set_ev)       exp_err = 1'b1;
        else if (err_clr) exp_err = 1'b0;
        check_val("err", {31'd0, err}, {31'd0, exp_err});
    endtask

    function automatic logic [C_N-1:0] junk(input logic [C_N-1:0] mask);
        return C_N'($urandom) & ~mask;
    endfunction

    // One full four-phase handshake. Branch i acks dly_r[i] edges after RISE
    // entry and drops dly_f[i] edges after FALL entry; gl[i] makes the rise a
    // one-cycle glitch.
    task automatic run_txn(input logic [C_N-1:0] mask, input logic [C_N-1:0] gl,
                           input int hdel, input int clr_k);
        int             c;
        int             cf;
        int             fe [C_N];
        logic [C_N-1:0] seen;
        c  = 1;
        cf = 1;
        for (int i = 0; i < C_N; i++) begin
            fe[i] = gl[i] ? 1 : dly_f[i];
            if (mask[i] && dly_r[i] > c) c  = dly_r[i];
            if (mask[i] && fe[i] > cf)   cf = fe[i];
        end

        in_req   = 1'b1;
        en_mask  = mask;
        out_acks = junk(mask);
        step(1'b0, 1'b0);
        check_val("rise_out_reqs", {29'd0, out_reqs}, {29'd0, mask});
        check_val("rise_pending0", {29'd0, pending}, {29'd0, mask});
        check_val("rise_busy", {31'd0, busy}, 32'd1);
        en_mask = C_N'($urandom);

        for (int k = 1; k <= c; k++) begin
            for (int i = 0; i < C_N; i++) begin
                if (mask[i]) out_acks[i] = gl[i] ? (dly_r[i] == k) : (dly_r[i] <= k);
                else         out_acks[i] = 1'($urandom);
            end
            step((k == C_TO) && (k < c), k == clr_k);
            for (int i = 0; i < C_N; i++) seen[i] = mask[i] && (dly_r[i] <= k);
            check_val("rise_in_ack", {31'd0, in_ack}, {31'd0, k == c});
            check_val("rise_pending", {29'd0, pending}, (k == c) ? 32'd0 : {29'd0, mask & ~seen});
            check_val("rise_reqs_hold", {29'd0, out_reqs}, {29'd0, mask});
        end

        for (int j = 1; j <= hdel; j++) begin
            in_req = (j < hdel);
            for (int i = 0; i < C_N; i++) begin
                if (mask[i]) out_acks[i] = !gl[i];
                else         out_acks[i] = 1'($urandom);
            end
            step(1'b0, 1'b0);
            check_val("hold_in_ack", {31'd0, in_ack}, 32'd1);
            check_val("hold_out_reqs", {29'd0, out_reqs}, (j < hdel) ? {29'd0, mask} : 32'd0);
            check_val("hold_pending", {29'd0, pending}, (j < hdel) ? 32'd0 : {29'd0, mask});
        end

        for (int k = 1; k <= cf; k++) begin
            for (int i = 0; i < C_N; i++) begin
                if (mask[i]) out_acks[i] = !gl[i] && (k < fe[i]);
                else         out_acks[i] = 1'($urandom);
            end
            step((k == C_TO) && (k < cf), 1'b0);
            for (int i = 0; i < C_N; i++) seen[i] = mask[i] && (fe[i] <= k);
            check_val("fall_in_ack", {31'd0, in_ack}, {31'd0, k != cf});
            check_val("fall_busy", {31'd0, busy}, {31'd0, k != cf});
            check_val("fall_pending", {29'd0, pending}, (k == cf) ? 32'd0 : {29'd0, mask & ~seen});
        end

        out_acks = junk(mask);
        step(1'b0, 1'b0);
        check_val("idle_in_ack", {31'd0, in_ack}, 32'd0);
        check_val("idle_busy", {31'd0, busy}, 32'd0);
        check_val("idle_out_reqs", {29'd0, out_reqs}, 32'd0);
    endtask

    task automatic reset_in_hold();
        in_req   = 1'b1;
        en_mask  = '1;
        out_acks = '0;
        step(1'b0, 1'b0);
        out_acks = '1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_val("pre_rst_in_ack", {31'd0, in_ack}, 32'd1);
        check_val("pre_rst_out_reqs", {29'd0, out_reqs}, 32'd7);
        #2 rstn = 1'b0;
        #1;
        exp_err = 1'b0;
        check_val("async_rst_in_ack", {31'd0, in_ack}, 32'd0);
        check_val("async_rst_out_reqs", {29'd0, out_reqs}, 32'd0);
        check_val("async_rst_busy", {31'd0, busy}, 32'd0);
        check_val("async_rst_pending", {29'd0, pending}, 32'd0);
        check_val("async_rst_err", {31'd0, err}, 32'd0);
        out_acks = '0;
        @(posedge clk);
        #3 rstn = 1'b1;
    endtask

    initial begin
        rstn     = 1'b0;
        in_req   = 1'b0;
        en_mask  = '0;
        out_acks = '0;
        err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ack", {31'd0, in_ack}, 32'd0);
        check_val("rst_out_reqs", {29'd0, out_reqs}, 32'd0);
        check_val("rst_pending", {29'd0, pending}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        #2 rstn = 1'b1;

        dly_r = '{3, 5, 4}; dly_f = '{2, 2, 4};
        run_txn(3'b111, 3'b000, 2, 0);
        dly_r = '{2, 1, 3}; dly_f = '{1, 5, 3};
        run_txn(3'b101, 3'b000, 1, 0);
        dly_r = '{1, 1, 1}; dly_f = '{1, 1, 1};
        run_txn(3'b000, 3'b000, 1, 0);
        dly_r = '{2, 3, C_TO + 3}; dly_f = '{1, 2, 1};
        run_txn(3'b111, 3'b000, 1, C_TO + 1);
        dly_r = '{1, 1, C_TO + 1}; dly_f = '{1, 1, 1};
        run_txn(3'b111, 3'b000, 1, C_TO);
        dly_r = '{1, 2, 1}; dly_f = '{1, C_TO + 2, 1};
        run_txn(3'b111, 3'b000, 2, 2);
        dly_r = '{2, 4, 3}; dly_f = '{3, 2, 2};
        run_txn(3'b111, 3'b001, 1, 0);
        reset_in_hold();
        dly_r = '{2, 2, 2}; dly_f = '{1, 1, 1};
        run_txn(3'b111, 3'b000, 1, 0);

        rand_clr = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [C_N-1:0] m;
            logic [C_N-1:0] g;
            for (int i = 0; i < C_N; i++) begin
                dly_r[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(C_TO - 1, C_TO + 3)
                                                      : $urandom_range(1, 6);
                dly_f[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(C_TO - 1, C_TO + 3)
                                                      : $urandom_range(1, 6);
            end
            m = C_N'($urandom);
            g = C_N'($urandom) & C_N'($urandom);
            run_txn(m, g, $urandom_range(1, 4), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
